// File: rtl/pool_ptr_alloc.sv
// pool_ptr_alloc: free-list buffer pointer allocator with per-WQE chain build.
// Ptrapply beats append one popped pointer to the open chain. An Fapply beat
// appends the final pointer, closes the chain and emits an allocation record.
// Freed pointers return through a separate stream. The next-pointer chain RAM
// exposes a registered read port for the data mover.
module pool_ptr_alloc #(
  parameter int WQE_INDEX_WIDTH   = 10,
  parameter int WQE_SOURCE_LENGTH = 11,
  parameter int PTR_WIDTH         = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         s_axis_Ptrapply_valid,
  output logic                         s_axis_Ptrapply_ready,
  input  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Ptrapply_id,
  input  logic                         s_axis_Fapply_valid,
  output logic                         s_axis_Fapply_ready,
  input  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Fapply_id,
  input  logic [WQE_SOURCE_LENGTH-1:0] s_axis_Fapply_len,
  input  logic                         s_axis_free_valid,
  output logic                         s_axis_free_ready,
  input  logic [PTR_WIDTH-1:0]         s_axis_free_ptr,
  output logic                         m_axis_alloc_valid,
  input  logic                         m_axis_alloc_ready,
  output logic [WQE_INDEX_WIDTH-1:0]   m_axis_alloc_id,
  output logic [PTR_WIDTH-1:0]         m_axis_alloc_head,
  output logic [WQE_SOURCE_LENGTH-1:0] m_axis_alloc_cnt,
  output logic [WQE_SOURCE_LENGTH-1:0] m_axis_alloc_len,
  input  logic [PTR_WIDTH-1:0]         next_rd_addr,
  output logic [PTR_WIDTH:0]           next_rd_data,
  output logic [PTR_WIDTH:0]           free_count,
  output logic                         init_done,
  output logic                         id_err
);

  localparam int                 POOL_DEPTH = 2**PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] DEPTH_CNT  = (PTR_WIDTH+1)'(POOL_DEPTH);
  localparam logic [WQE_SOURCE_LENGTH-1:0] CNT_ONE = WQE_SOURCE_LENGTH'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Chain length increments saturate at all-ones.
  function automatic logic [WQE_SOURCE_LENGTH-1:0] sat_inc(
    input logic [WQE_SOURCE_LENGTH-1:0] v
  );
    logic [WQE_SOURCE_LENGTH-1:0] res;
    if (&v) res = v;
    else    res = v + CNT_ONE;
    return res;
  endfunction

  state_t                         r_state;
  logic [PTR_WIDTH:0]             r_init_cnt;
  logic [PTR_WIDTH:0]             r_free_cnt;
  logic [PTR_WIDTH-1:0]           r_wr_ptr;
  logic [PTR_WIDTH-1:0]           r_rd_ptr;
  logic [PTR_WIDTH-1:0]           r_free_ram [POOL_DEPTH];
  logic [PTR_WIDTH:0]             r_next_ram [POOL_DEPTH];
  logic [PTR_WIDTH:0]             r_next_rd_data;
  logic                           r_init_done;
  logic                           r_id_err;
  logic                           r_chain_open;
  logic [PTR_WIDTH-1:0]           r_head;
  logic [PTR_WIDTH-1:0]           r_tail;
  logic [WQE_SOURCE_LENGTH-1:0]   r_cnt;
  logic [WQE_INDEX_WIDTH-1:0]     r_chain_id;
  logic                           r_alloc_valid;
  logic [WQE_INDEX_WIDTH-1:0]     r_alloc_id;
  logic [PTR_WIDTH-1:0]           r_alloc_head;
  logic [WQE_SOURCE_LENGTH-1:0]   r_alloc_cnt;
  logic [WQE_SOURCE_LENGTH-1:0]   r_alloc_len;

  logic                           w_run;
  logic                           w_has_free;
  logic                           w_has_room;
  logic                           w_ptr_ready;
  logic                           w_fin_ready;
  logic                           w_free_ready;
  logic                           w_ptr_fire;
  logic                           w_fin_fire;
  logic                           w_pop;
  logic                           w_push;
  logic [PTR_WIDTH-1:0]           w_pop_ptr;
  logic [WQE_INDEX_WIDTH-1:0]     w_req_id;

  assign w_run        = (r_state == ST_RUN);
  assign w_has_free   = (r_free_cnt != {(PTR_WIDTH+1){1'b0}});
  assign w_has_room   = (r_free_cnt < DEPTH_CNT);
  // Ptrapply wins over Fapply; Fapply also needs the record slot to be free
  // or draining this cycle.
  assign w_ptr_ready  = w_run & w_has_free;
  assign w_fin_ready  = w_run & w_has_free & ~s_axis_Ptrapply_valid &
                        (~r_alloc_valid | m_axis_alloc_ready);
  assign w_free_ready = w_run & w_has_room;
  assign w_ptr_fire   = s_axis_Ptrapply_valid & w_ptr_ready;
  assign w_fin_fire   = s_axis_Fapply_valid & w_fin_ready;
  assign w_pop        = w_ptr_fire | w_fin_fire;
  assign w_push       = s_axis_free_valid & w_free_ready;
  assign w_pop_ptr    = r_free_ram[r_rd_ptr];
  assign w_req_id     = w_ptr_fire ? s_axis_Ptrapply_id : s_axis_Fapply_id;

  assign s_axis_Ptrapply_ready = w_ptr_ready;
  assign s_axis_Fapply_ready   = w_fin_ready;
  assign s_axis_free_ready     = w_free_ready;
  assign m_axis_alloc_valid    = r_alloc_valid;
  assign m_axis_alloc_id       = r_alloc_id;
  assign m_axis_alloc_head     = r_alloc_head;
  assign m_axis_alloc_cnt      = r_alloc_cnt;
  assign m_axis_alloc_len      = r_alloc_len;
  assign next_rd_data          = r_next_rd_data;
  assign free_count            = r_free_cnt;
  assign init_done             = r_init_done;
  assign id_err                = r_id_err;

  // Control FSM: sequences free-list init, then tracks pointers and occupancy.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= {(PTR_WIDTH+1){1'b0}};
      r_free_cnt  <= {(PTR_WIDTH+1){1'b0}};
      r_wr_ptr    <= {PTR_WIDTH{1'b0}};
      r_rd_ptr    <= {PTR_WIDTH{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == DEPTH_CNT) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
            r_free_cnt  <= DEPTH_CNT;
            r_wr_ptr    <= {PTR_WIDTH{1'b0}};
            r_rd_ptr    <= {PTR_WIDTH{1'b0}};
          end else begin
            r_init_cnt  <= r_init_cnt + (PTR_WIDTH+1)'(1);
          end
        end
        ST_RUN: begin
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
          end else begin
            r_rd_ptr <= r_rd_ptr;
          end
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
          end else begin
            r_wr_ptr <= r_wr_ptr;
          end
          case ({w_push, w_pop})
            2'b10:   r_free_cnt <= r_free_cnt + (PTR_WIDTH+1)'(1);
            2'b01:   r_free_cnt <= r_free_cnt - (PTR_WIDTH+1)'(1);
            default: r_free_cnt <= r_free_cnt;
          endcase
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Free-list storage: identity fill during init, returned pointers in run.
  always_ff @(posedge sys_clk) begin
    if (r_state == ST_INIT && r_init_cnt != DEPTH_CNT) begin
      r_free_ram[r_init_cnt[PTR_WIDTH-1:0]] <= r_init_cnt[PTR_WIDTH-1:0];
    end else if (w_push) begin
      r_free_ram[r_wr_ptr] <= s_axis_free_ptr;
    end
  end

  // Chain RAM writes: link the old tail forward, self-loop the final pointer.
  always_ff @(posedge sys_clk) begin
    if (w_pop && r_chain_open) begin
      r_next_ram[r_tail] <= {1'b0, w_pop_ptr};
    end
    if (w_fin_fire) begin
      r_next_ram[w_pop_ptr] <= {1'b1, w_pop_ptr};
    end
  end

  // Registered chain RAM read port for the data mover.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_next_rd_data <= {(PTR_WIDTH+1){1'b0}};
    end else begin
      r_next_rd_data <= r_next_ram[next_rd_addr];
    end
  end

  // Open-chain bookkeeping and sticky id mismatch detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_chain_open <= 1'b0;
      r_head       <= {PTR_WIDTH{1'b0}};
      r_tail       <= {PTR_WIDTH{1'b0}};
      r_cnt        <= {WQE_SOURCE_LENGTH{1'b0}};
      r_chain_id   <= {WQE_INDEX_WIDTH{1'b0}};
      r_id_err     <= 1'b0;
    end else if (w_pop) begin
      if (!r_chain_open) begin
        r_head     <= w_pop_ptr;
        r_tail     <= w_pop_ptr;
        r_cnt      <= CNT_ONE;
        r_chain_id <= w_req_id;
      end else begin
        r_tail     <= w_pop_ptr;
        r_cnt      <= sat_inc(r_cnt);
        if (r_chain_id != w_req_id) begin
          r_id_err <= 1'b1;
        end
      end
      // A final beat closes the chain; an intermediate beat leaves it open.
      r_chain_open <= w_ptr_fire;
    end
  end

  // Allocation record: load on Fapply, hold until the consumer takes it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_alloc_valid <= 1'b0;
      r_alloc_id    <= {WQE_INDEX_WIDTH{1'b0}};
      r_alloc_head  <= {PTR_WIDTH{1'b0}};
      r_alloc_cnt   <= {WQE_SOURCE_LENGTH{1'b0}};
      r_alloc_len   <= {WQE_SOURCE_LENGTH{1'b0}};
    end else if (w_fin_fire) begin
      r_alloc_valid <= 1'b1;
      r_alloc_id    <= s_axis_Fapply_id;
      r_alloc_head  <= r_chain_open ? r_head : w_pop_ptr;
      r_alloc_cnt   <= r_chain_open ? sat_inc(r_cnt) : CNT_ONE;
      r_alloc_len   <= s_axis_Fapply_len;
    end else if (m_axis_alloc_ready) begin
      r_alloc_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_ptr_alloc.sv
// Self-checking bench for pool_ptr_alloc: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_pool_ptr_alloc;
  localparam int IW    = 10;
  localparam int LW    = 11;
  localparam int PW    = 4;
  localparam int DEPTH = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          s_axis_Ptrapply_valid = 1'b0;
  logic          s_axis_Ptrapply_ready;
  logic [IW-1:0] s_axis_Ptrapply_id = '0;
  logic          s_axis_Fapply_valid = 1'b0;
  logic          s_axis_Fapply_ready;
  logic [IW-1:0] s_axis_Fapply_id = '0;
  logic [LW-1:0] s_axis_Fapply_len = '0;
  logic          s_axis_free_valid = 1'b0;
  logic          s_axis_free_ready;
  logic [PW-1:0] s_axis_free_ptr = '0;
  logic          m_axis_alloc_valid;
  logic          m_axis_alloc_ready = 1'b0;
  logic [IW-1:0] m_axis_alloc_id;
  logic [PW-1:0] m_axis_alloc_head;
  logic [LW-1:0] m_axis_alloc_cnt;
  logic [LW-1:0] m_axis_alloc_len;
  logic [PW-1:0] next_rd_addr = '0;
  logic [PW:0]   next_rd_data;
  logic [PW:0]   free_count;
  logic          init_done;
  logic          id_err;

  pool_ptr_alloc #(.WQE_INDEX_WIDTH(IW), .WQE_SOURCE_LENGTH(LW), .PTR_WIDTH(PW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_axis_Ptrapply_valid(s_axis_Ptrapply_valid), .s_axis_Ptrapply_ready(s_axis_Ptrapply_ready),
    .s_axis_Ptrapply_id(s_axis_Ptrapply_id),
    .s_axis_Fapply_valid(s_axis_Fapply_valid), .s_axis_Fapply_ready(s_axis_Fapply_ready),
    .s_axis_Fapply_id(s_axis_Fapply_id), .s_axis_Fapply_len(s_axis_Fapply_len),
    .s_axis_free_valid(s_axis_free_valid), .s_axis_free_ready(s_axis_free_ready),
    .s_axis_free_ptr(s_axis_free_ptr),
    .m_axis_alloc_valid(m_axis_alloc_valid), .m_axis_alloc_ready(m_axis_alloc_ready),
    .m_axis_alloc_id(m_axis_alloc_id), .m_axis_alloc_head(m_axis_alloc_head),
    .m_axis_alloc_cnt(m_axis_alloc_cnt), .m_axis_alloc_len(m_axis_alloc_len),
    .next_rd_addr(next_rd_addr), .next_rd_data(next_rd_data),
    .free_count(free_count), .init_done(init_done), .id_err(id_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int free_q[$];
  int chain_q[$];
  int chain_id;
  bit run;
  bit m_valid;
  int m_id, m_head, m_cnt, m_len;
  bit m_err;
  int nr[DEPTH];
  bit nr_ok[DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Returns a pointer that is currently held by a completed allocation, or -1.
  function automatic int pick_free();
    int cand[$];
    for (int v = 0; v < DEPTH; v++) begin
      bit used;
      used = 1'b0;
      foreach (free_q[i]) if (free_q[i] == v) used = 1'b1;
      foreach (chain_q[i]) if (chain_q[i] == v) used = 1'b1;
      if (!used) cand.push_back(v);
    end
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(cand.size() - 1, 0)];
  endfunction

  // One clock cycle: drive, check readies, advance model, check outputs.
  task automatic cycle(input bit pv, input int pid, input bit fv, input int fid,
                       input int flen, input bit frv, input int fptr,
                       input bit ar, input int rda);
    bit epr, efr, efrr, pf, ff, qf, erd_ok;
    int p, erd, rid;
    s_axis_Ptrapply_valid = pv;
    s_axis_Ptrapply_id    = IW'(pid);
    s_axis_Fapply_valid   = fv;
    s_axis_Fapply_id      = IW'(fid);
    s_axis_Fapply_len     = LW'(flen);
    s_axis_free_valid     = frv;
    s_axis_free_ptr       = PW'(fptr);
    m_axis_alloc_ready    = ar;
    next_rd_addr          = PW'(rda);
    #1;
    epr  = run && (free_q.size() != 0);
    efr  = epr && !pv && (!m_valid || ar);
    efrr = run && (free_q.size() < DEPTH);
    chk("ptr_ready",  32'(s_axis_Ptrapply_ready), 32'(epr));
    chk("fin_ready",  32'(s_axis_Fapply_ready),   32'(efr));
    chk("free_ready", 32'(s_axis_free_ready),     32'(efrr));
    erd_ok = nr_ok[rda];
    erd    = nr[rda];
    pf = pv && epr;
    ff = fv && efr;
    qf = frv && efrr;
    if (!ff && ar) m_valid = 1'b0;
    if (pf || ff) begin
      rid = pf ? pid : fid;
      p = free_q.pop_front();
      nr_ok[p] = 1'b0;
      if (chain_q.size() == 0) chain_id = rid;
      else if (chain_id != rid) m_err = 1'b1;
      chain_q.push_back(p);
      if (ff) begin
        for (int i = 0; i < chain_q.size() - 1; i++) begin
          nr[chain_q[i]]    = chain_q[i+1];
          nr_ok[chain_q[i]] = 1'b1;
        end
        nr[p]    = DEPTH + p;
        nr_ok[p] = 1'b1;
        m_valid = 1'b1;
        m_id    = fid;
        m_head  = chain_q[0];
        m_cnt   = chain_q.size();
        m_len   = flen;
        chain_q.delete();
      end
    end
    if (qf) free_q.push_back(fptr);
    @(posedge sys_clk);
    #1;
    chk("free_count",  32'(free_count),         32'(free_q.size()));
    chk("alloc_valid", 32'(m_axis_alloc_valid), 32'(m_valid));
    chk("id_err",      32'(id_err),             32'(m_err));
    if (m_valid) begin
      chk("alloc_id",   32'(m_axis_alloc_id),   32'(m_id));
      chk("alloc_head", 32'(m_axis_alloc_head), 32'(m_head));
      chk("alloc_cnt",  32'(m_axis_alloc_cnt),  32'(m_cnt));
      chk("alloc_len",  32'(m_axis_alloc_len),  32'(m_len));
    end
    if (erd_ok) chk("next_rd_data", 32'(next_rd_data), 32'(erd));
  endtask

  task automatic idle(input bit ar, input int rda);
    cycle(0, 0, 0, 0, 0, 0, 0, ar, rda);
  endtask

  task automatic ptr(input int id, input bit ar);
    cycle(1, id, 0, 0, 0, 0, 0, ar, 0);
  endtask

  task automatic fin(input int id, input int len, input bit ar);
    cycle(0, 0, 1, id, len, 0, 0, ar, 0);
  endtask

  task automatic fr(input int p);
    cycle(0, 0, 0, 0, 0, 1, p, 1, 0);
  endtask

  // Asserts reset asynchronously, checks reset values, then times init.
  task automatic do_reset_init();
    int n;
    bit seen;
    s_axis_Ptrapply_valid = 1'b0;
    s_axis_Fapply_valid   = 1'b0;
    s_axis_free_valid     = 1'b0;
    m_axis_alloc_ready    = 1'b0;
    #3;
    sys_rst = 1'b1;
    #1;
    chk("rst_alloc_valid", 32'(m_axis_alloc_valid), 32'd0);
    chk("rst_init_done",   32'(init_done),          32'd0);
    chk("rst_id_err",      32'(id_err),             32'd0);
    chk("rst_free_count",  32'(free_count),         32'd0);
    chk("rst_readies", 32'({s_axis_Ptrapply_ready, s_axis_Fapply_ready, s_axis_free_ready}), 32'd0);
    chk("rst_alloc_idhd",  32'({m_axis_alloc_id, m_axis_alloc_head}), 32'd0);
    chk("rst_alloc_cntln", 32'({m_axis_alloc_cnt, m_axis_alloc_len}), 32'd0);
    free_q.delete();
    chain_q.delete();
    run = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) nr_ok[i] = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge sys_clk);
      #1;
      if (init_done) begin
        seen = 1'b1;
        n = k;
      end else begin
        chk("init_readies", 32'({s_axis_Ptrapply_ready, s_axis_Fapply_ready, s_axis_free_ready}), 32'd0);
      end
    end
    chk("init_latency", 32'(n), 32'd17);
    chk("init_free_count", 32'(free_count), 32'd16);
    run = 1'b1;
    for (int i = 0; i < DEPTH; i++) free_q.push_back(i);
  endtask

  initial begin
    int fp;
    // Reset and init timing
    do_reset_init();

    // Three intermediate pointers then the final one for WQE 5
    ptr(5, 0); ptr(5, 0); ptr(5, 0);
    fin(5, 300, 0);
    chk("s2_alloc_cnt", 32'(m_axis_alloc_cnt), 32'd4);
    chk("s2_free_count", 32'(free_count), 32'd12);
    for (int a = 0; a < 4; a++) idle(1, a);
    idle(1, 3);

    // Drain the remaining 12 pointers, then try to pop from an empty pool
    for (int i = 0; i < 11; i++) ptr(6, 1);
    fin(6, 40, 1);
    cycle(1, 7, 1, 7, 1, 0, 0, 1, 0);
    chk("s3_empty_ptr_ready", 32'(s_axis_Ptrapply_ready), 32'd0);
    fr(9);
    ptr(7, 1);

    // Refill to 7, then pop and free in the same cycle
    for (int p = 0; p < 7; p++) fr(p);
    cycle(1, 7, 0, 0, 0, 1, 10, 1, 0);
    chk("s4_free_count_hold", 32'(free_count), 32'd7);
    for (int i = 0; i < 7; i++) ptr(7, 1);

    // Backpressure on the allocation record
    for (int p = 11; p < 15; p++) fr(p);
    fin(7, 77, 0);
    ptr(8, 0); ptr(8, 0);
    fin(8, 88, 0); fin(8, 88, 0); fin(8, 88, 0);
    fin(8, 88, 1);
    idle(1, 11);

    // Id mismatch between intermediate and final beat
    fr(0); fr(1); fr(2);
    ptr(2, 1);
    fin(3, 5, 1);
    chk("s6_id_err", 32'(id_err), 32'd1);
    idle(1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      fp = pick_free();
      cycle(($urandom_range(2, 0) == 0), int'($urandom_range(1, 0)),
            ($urandom_range(3, 0) == 0), int'($urandom_range(1, 0)), int'($urandom_range(2047, 0)),
            (fp >= 0) && ($urandom_range(1, 0) == 1), (fp >= 0) ? fp : 0,
            $urandom_range(1, 0), int'($urandom_range(15, 0)));
    end

    // Reset with a chain open, then rerun init and a short chain
    ptr(4, 1);
    do_reset_init();
    ptr(1, 1);
    fin(1, 9, 1);
    idle(1, 0);
    idle(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
